// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Two-requester round-robin arbiter onto a shared SRAM port with
//           slave-wait timeout and sticky error flag.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    input  logic        err_clr,
    output logic        timeout_err,
    output logic [1:0]  grant
);

    localparam logic [7:0] c_timeout = 8'(TIMEOUT_CYCLES);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_grant, w_grant_nxt;
    logic        r_last_m1, w_last_m1_nxt;
    logic [7:0]  r_wait_cnt, w_wait_cnt_nxt;
    logic        r_timeout_err;

    logic        w_busy;
    logic        w_owner_valid;
    logic        w_timeout;
    logic        w_done;
    logic [31:0] w_rdata;

    assign w_busy        = (r_state == S_BUSY);
    assign w_owner_valid = (r_grant[0] & m0_valid) | (r_grant[1] & m1_valid);
    // Timeout only fires when the slave is still silent; a same-cycle s_ready wins.
    assign w_timeout     = w_busy & w_owner_valid & ~s_ready & (r_wait_cnt == c_timeout);
    assign w_done        = w_busy & w_owner_valid & (s_ready | w_timeout);
    assign w_rdata       = s_ready ? s_rdata : ERR_RDATA;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_grant       <= 2'b00;
            r_last_m1     <= 1'b1;
            r_wait_cnt    <= 8'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_last_m1  <= w_last_m1_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_timeout)
                r_timeout_err <= 1'b1;
            else if (err_clr)
                r_timeout_err <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_last_m1_nxt  = r_last_m1;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            S_IDLE: begin
                w_wait_cnt_nxt = 8'd0;
                if (m0_valid && m1_valid) begin
                    w_grant_nxt = r_last_m1 ? 2'b01 : 2'b10;
                    w_state_nxt = S_BUSY;
                end else if (m0_valid) begin
                    w_grant_nxt = 2'b01;
                    w_state_nxt = S_BUSY;
                end else if (m1_valid) begin
                    w_grant_nxt = 2'b10;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (!w_owner_valid) begin
                    // Owner withdrew: abandon without touching round-robin history.
                    w_grant_nxt = 2'b00;
                    w_state_nxt = S_IDLE;
                end else if (w_done) begin
                    w_grant_nxt   = 2'b00;
                    w_last_m1_nxt = r_grant[1];
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                end
            end
            default: begin
                w_grant_nxt = 2'b00;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // grant is 00 whenever idle, so the AND-OR mux drives zeros then.
    assign s_valid  = w_busy;
    assign s_addr   = ({32{r_grant[0]}} & m0_addr)  | ({32{r_grant[1]}} & m1_addr);
    assign s_wdata  = ({32{r_grant[0]}} & m0_wdata) | ({32{r_grant[1]}} & m1_wdata);
    assign s_wstrb  = ({4{r_grant[0]}}  & m0_wstrb) | ({4{r_grant[1]}}  & m1_wstrb);

    assign m0_ready = w_done & r_grant[0];
    assign m1_ready = w_done & r_grant[1];
    assign m0_rdata = m0_ready ? w_rdata : 32'd0;
    assign m1_rdata = m1_ready ? w_rdata : 32'd0;

    assign timeout_err = r_timeout_err;
    assign grant       = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Directed self-checking bench for mem_arbiter (TIMEOUT_CYCLES=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_valid, m1_valid;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        err_clr;
    logic        timeout_err;
    logic [1:0]  grant;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(
        .TIMEOUT_CYCLES(4),
        .ERR_RDATA     (32'hDEAD_BEEF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0_valid   (m0_valid),
        .m0_ready   (m0_ready),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_wstrb   (m0_wstrb),
        .m0_rdata   (m0_rdata),
        .m1_valid   (m1_valid),
        .m1_ready   (m1_ready),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_wstrb   (m1_wstrb),
        .m1_rdata   (m1_rdata),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_wstrb    (s_wstrb),
        .s_rdata    (s_rdata),
        .err_clr    (err_clr),
        .timeout_err(timeout_err),
        .grant      (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here, checks 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        s_ready = 0; s_rdata = 0; err_clr = 0;
        #3;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_s_valid", 32'(s_valid), 32'd0);
        chk("rst_ready", 32'({m1_ready, m0_ready}), 32'd0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        chk("rst_s_addr", s_addr, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Single read, slave answers one cycle after s_valid.
        m0_valid = 1; m0_addr = 32'h100; m0_wstrb = 4'h0;
        #1;
        chk("rd_c0_s_valid", 32'(s_valid), 32'd0);
        tick();
        #1;
        chk("rd_c1_s_valid", 32'(s_valid), 32'd1);
        chk("rd_c1_grant", 32'(grant), 32'd1);
        chk("rd_c1_s_addr", s_addr, 32'h100);
        chk("rd_c1_m0_ready", 32'(m0_ready), 32'd0);
        tick();
        s_ready = 1; s_rdata = 32'h1234_5678;
        #1;
        chk("rd_c2_m0_ready", 32'(m0_ready), 32'd1);
        chk("rd_c2_m0_rdata", m0_rdata, 32'h1234_5678);
        chk("rd_c2_m1_ready", 32'(m1_ready), 32'd0);
        chk("rd_c2_m1_rdata", m1_rdata, 32'd0);
        tick();
        m0_valid = 0; s_ready = 0;
        #1;
        chk("rd_idle_grant", 32'(grant), 32'd0);
        chk("rd_idle_s_valid", 32'(s_valid), 32'd0);
        chk("rd_idle_s_addr", s_addr, 32'd0);

        // Fresh reset so m0 wins the first contention, then alternating writes.
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
        m0_valid = 1; m0_addr = 32'h200; m0_wdata = 32'hAAAA_0000; m0_wstrb = 4'hF;
        m1_valid = 1; m1_addr = 32'h300; m1_wdata = 32'hBBBB_0000; m1_wstrb = 4'h3;
        for (int i = 0; i < 4; i++) begin
            s_ready = 0;
            #1;
            chk("rr_idle_grant", 32'(grant), 32'd0);
            tick();
            #1;
            chk("rr_grant", 32'(grant), (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("rr_wstrb", 32'(s_wstrb), (i % 2 == 0) ? 32'hF : 32'h3);
            chk("rr_wdata", s_wdata, (i % 2 == 0) ? 32'hAAAA_0000 : 32'hBBBB_0000);
            chk("rr_wait_ready", 32'({m1_ready, m0_ready}), 32'd0);
            tick();
            s_ready = 1; s_rdata = 32'h0;
            #1;
            chk("rr_ready", 32'({m1_ready, m0_ready}), (i % 2 == 0) ? 32'd1 : 32'd2);
            tick();
        end
        m0_valid = 0; m1_valid = 0; s_ready = 0;
        m0_wstrb = 0; m1_wstrb = 0;
        tick();

        // Timeout: slave never answers; err_clr in the timeout cycle must lose.
        m0_valid = 1; m0_addr = 32'h400;
        tick();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("to_wait_ready", 32'(m0_ready), 32'd0);
            tick();
        end
        err_clr = 1;
        #1;
        chk("to_ready", 32'(m0_ready), 32'd1);
        chk("to_rdata", m0_rdata, 32'hDEAD_BEEF);
        tick();
        m0_valid = 0; err_clr = 0;
        #1;
        chk("to_terr_set", 32'(timeout_err), 32'd1);
        chk("to_s_valid_low", 32'(s_valid), 32'd0);
        err_clr = 1;
        tick();
        err_clr = 0;
        #1;
        chk("to_terr_clr", 32'(timeout_err), 32'd0);
        tick();

        // s_ready arrives exactly when the counter reaches the limit.
        m0_valid = 1; m0_addr = 32'h404;
        tick();
        for (int k = 0; k < 4; k++) tick();
        s_ready = 1; s_rdata = 32'hCAFE_F00D;
        #1;
        chk("edge_ready", 32'(m0_ready), 32'd1);
        chk("edge_rdata", m0_rdata, 32'hCAFE_F00D);
        tick();
        m0_valid = 0; s_ready = 0;
        #1;
        chk("edge_terr", 32'(timeout_err), 32'd0);
        tick();

        // Reset in the middle of a 3-cycle slave transfer.
        m1_valid = 1; m1_addr = 32'h500;
        tick();
        #1;
        chk("mr_grant", 32'(grant), 32'd2);
        tick();
        rst_n = 0;
        #1;
        chk("mr_grant_rst", 32'(grant), 32'd0);
        chk("mr_s_valid_rst", 32'(s_valid), 32'd0);
        tick();
        rst_n = 1; s_ready = 1; s_rdata = 32'h5555_5555;
        #1;
        chk("mr_no_ready", 32'(m1_ready), 32'd0);
        tick();
        s_ready = 0;
        tick();
        tick();
        s_ready = 1; s_rdata = 32'h0BAD_CAFE;
        #1;
        chk("mr_next_ready", 32'(m1_ready), 32'd1);
        chk("mr_next_rdata", m1_rdata, 32'h0BAD_CAFE);
        tick();
        m1_valid = 0; s_ready = 0;
        tick();

        // m1 withdraws mid-transfer; pending m0 is granted after one idle cycle.
        m1_valid = 1; m1_addr = 32'h600;
        tick();
        m0_valid = 1; m0_addr = 32'h700;
        #1;
        chk("ab_grant_m1", 32'(grant), 32'd2);
        chk("ab_m0_ready", 32'(m0_ready), 32'd0);
        tick();
        m1_valid = 0;
        #1;
        chk("ab_m1_ready", 32'(m1_ready), 32'd0);
        tick();
        #1;
        chk("ab_idle_grant", 32'(grant), 32'd0);
        chk("ab_idle_m1_ready", 32'(m1_ready), 32'd0);
        tick();
        #1;
        chk("ab_grant_m0", 32'(grant), 32'd1);
        chk("ab_s_addr_m0", s_addr, 32'h700);
        tick();
        s_ready = 1; s_rdata = 32'h7777_7777;
        #1;
        chk("ab_m0_done", 32'(m0_ready), 32'd1);
        chk("ab_m1_quiet", 32'(m1_ready), 32'd0);
        tick();
        m0_valid = 0; s_ready = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max slave-wait cycles before forced completion (range 1..255).
REQ-002 Parameter ERR_RDATA, default 32'hDEAD_BEEF, read data returned on timeout.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 m0_valid / m1_valid  input  1  requester 0 (CPU) / requester 1 (DMA) request, PicoRV32 native semantics.
REQ-006 m0_ready / m1_ready  output  1  transfer-complete pulse to requester.
REQ-007 m0_addr, m0_wdata / m1_addr, m1_wdata  input  32  address, write data.
REQ-008 m0_wstrb / m1_wstrb  input  4  byte strobes; 0 = read.
REQ-009 m0_rdata / m1_rdata  output  32  read data, valid only while own ready=1.
REQ-010 s_valid  output  1  request to shared SRAM wrapper.
REQ-011 s_ready  input  1  SRAM wrapper completion.
REQ-012 s_addr, s_wdata  output  32; s_wstrb  output  4; s_rdata  input  32.
REQ-013 err_clr  input  1  synchronous clear of timeout_err.
REQ-014 timeout_err  output  1  sticky flag: a timeout has occurred.
REQ-015 grant  output  2  one-hot owner (bit0=m0, bit1=m1); 2'b00 when idle.

Function
REQ-016 FSM states IDLE, BUSY; reset state IDLE.
REQ-017 IDLE, no valid: stay IDLE, grant=00, s_valid=0.
REQ-018 IDLE, exactly one valid: register grant to that requester, go BUSY next edge.
REQ-019 IDLE, both valid: grant requester not served last (round-robin); last_served resets to m1, so m0 wins first contention.
REQ-020 BUSY: s_valid=1; s_addr/s_wdata/s_wstrb combinationally muxed from granted requester; non-granted ready=0.
REQ-021 When idle, s_addr/s_wdata/s_wstrb = 0.
REQ-022 BUSY and s_ready=1: granted mX_ready=1 and mX_rdata=s_rdata same cycle; update last_served; go IDLE next edge.
REQ-023 Minimum latency valid->ready = 2 cycles (1 arbitration + 1 slave) with zero-wait slave.
REQ-024 Back-to-back: requester may be re-granted from IDLE the cycle after completion; no BUSY->BUSY transition.
REQ-025 Wait counter (8-bit) clears on entering BUSY, increments each BUSY cycle with s_ready=0.
REQ-026 Counter reaching TIMEOUT_CYCLES with s_ready=0: granted ready=1, rdata=ERR_RDATA, timeout_err set, go IDLE; s_valid low next cycle.
REQ-027 s_ready=1 on timeout cycle: normal completion takes priority, no error.
REQ-028 Granted valid deasserts in BUSY: abort, go IDLE next edge, no ready pulse, last_served unchanged.
REQ-029 err_clr and new timeout same cycle: timeout_err remains 1 (set wins).
REQ-030 Non-granted requester held off indefinitely only while owner BUSY; round-robin bounds wait to one transfer.
REQ-031 rdata outputs 0 whenever own ready=0.

Reset
REQ-032 rst_n low asynchronously forces IDLE, grant=00, s_valid=0, m0_ready=m1_ready=0, rdata=0, counter=0, timeout_err=0, last_served=m1.
REQ-033 Reset mid-BUSY abandons transfer; no ready pulse after deassertion; arbitration restarts from IDLE.

Verification
REQ-034 m0 read addr 0x100, zero-wait slave returns 0x1234_5678 -> s_valid cycle 1, m0_ready+rdata 0x1234_5678 cycle 2, m1 idle.
REQ-035 m0, m1 both valid continuously, writes -> grants alternate m0,m1,m0,m1; each ready once per grant; s_wstrb matches owner.
REQ-036 s_ready held 0, TIMEOUT_CYCLES=4 -> ready with 0xDEAD_BEEF after 4 wait cycles, timeout_err=1; err_clr pulse -> 0.
REQ-037 s_ready at exactly count 4 (TIMEOUT_CYCLES=4) -> normal rdata, timeout_err stays 0.
REQ-038 rst_n low during BUSY with 3-cycle slave -> outputs reset immediately, no ready after release, next request served normally.
REQ-039 m1 drops valid mid-BUSY -> IDLE next cycle, no m1_ready, pending m0 granted following cycle.
